// File: rtl/subtrator_serial.sv
// Bit-serial unsigned subtractor: D = A - B - Bin, one bit per clock, LSB first.
// Optional signed-overflow flag output (ovf) enabled by defining SUBTRATOR_OVF_EN.
module subtrator_serial #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         busy,
    output logic         done,
    output logic [N:0]   D
`ifdef SUBTRATOR_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [N-1:0]  diff;
    logic [N-1:0]  diff_nx;
    logic          br;
    logic          a_bit;
    logic          b_bit;
    logic          d_bit;
    logic          br_nx;
    logic          last;
    logic          load;
    logic          step;
    logic          busy_nx;
    logic          done_nx;

    // One-bit full-subtractor slice over the operand bit selected by the counter
    always_comb begin
        a_bit   = a_reg[cnt];
        b_bit   = b_reg[cnt];
        d_bit   = a_bit ^ b_bit ^ br;
        br_nx   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
        last    = (cnt == CW'(N - 1));
        diff_nx = diff;
        diff_nx[cnt] = d_bit;
    end

    // Next-state and registered-output decode
    always_comb begin
        state_nx = state;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    busy_nx  = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                step    = 1'b1;
                busy_nx = 1'b1;
                if (last) begin
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load     = 1'b1;
                    busy_nx  = 1'b1;
                    state_nx = SHIFT;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, control outputs, operand latch and serial datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            D     <= '0;
            cnt   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            diff  <= '0;
            br    <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            if (load) begin
                a_reg <= A;
                b_reg <= B;
                br    <= Bin;
                cnt   <= '0;
                diff  <= '0;
            end else if (step) begin
                diff <= diff_nx;
                br   <= br_nx;
                cnt  <= cnt + CW'(1);
                if (last) begin
                    D <= {br_nx, diff_nx};
                end
            end
        end
    end

`ifdef SUBTRATOR_OVF_EN
    // Signed overflow: operand signs differ and result sign differs from minuend sign
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (step && last) begin
            ovf <= (a_reg[N-1] ^ b_reg[N-1]) & (d_bit ^ a_reg[N-1]);
        end
    end
`endif

endmodule

// File: tb/tb_subtrator_serial.sv
// Self-checking bench for subtrator_serial: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_subtrator_serial;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bin;
    logic         busy;
    logic         done;
    logic [N:0]   D;
`ifdef SUBTRATOR_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    logic [N:0] exp_d = '0;
    logic       exp_ovf = 1'b0;

    subtrator_serial #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .D     (D)
`ifdef SUBTRATOR_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic, unsigned and two's-complement views
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
        int r;
        int sa;
        int sb;
        int sr;
        r  = int'(a) - int'(b) - int'(bin);
        exp_d = (N+1)'(r);
        sa = a[N-1] ? int'(a) - (1 << N) : int'(a);
        sb = b[N-1] ? int'(b) - (1 << N) : int'(b);
        sr = sa - sb - int'(bin);
        exp_ovf = (sr < -(1 << (N - 1))) || (sr > (1 << (N - 1)) - 1);
    endtask

    // Issue one operation from IDLE or DONE; optionally re-pulse start mid-shift
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                         input bit poke);
        logic [N:0] prev;
        prev  = exp_d;
        A     = a;
        B     = b;
        Bin   = bin;
        start = 1'b1;
        tick();
        check("busy_e0", 32'(busy), 32'd1);
        check("done_e0", 32'(done), 32'd0);
        check("hold_e0", 32'(D), 32'(prev));
        start = 1'b0;
        A     = N'($urandom);
        B     = N'($urandom);
        Bin   = 1'($urandom);
        for (int i = 1; i < int'(N); i++) begin
            start = (poke && i == 2) ? 1'b1 : 1'b0;
            tick();
            check("busy_shift", 32'(busy), 32'd1);
            check("done_shift", 32'(done), 32'd0);
            check("hold_shift", 32'(D), 32'(prev));
        end
        start = 1'b0;
        tick();
        model(a, b, bin);
        check("done_eN", 32'(done), 32'd1);
        check("busy_eN", 32'(busy), 32'd1);
        check("result", 32'(D), 32'(exp_d));
`ifdef SUBTRATOR_OVF_EN
        check("ovf", 32'(ovf), 32'(exp_ovf));
`endif
    endtask

    // One idle cycle after completion: pulse must be gone and result held
    task automatic idle_check();
        start = 1'b0;
        tick();
        check("done_idle", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("hold_idle", 32'(D), 32'(exp_d));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        Bin   = 1'b0;
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_d", 32'(D), 32'd0);
        #4;
        rst = 1'b0;

        // Directed cases, start on the first edge after reset release
        do_op(4'b0010, 4'b1000, 1'b0, 1'b0);
        check("d_case1", 32'(D), 32'h1A);
        idle_check();
        do_op(4'b0110, 4'b1010, 1'b0, 1'b0);
        check("d_case2", 32'(D), 32'h1C);
        idle_check();
        do_op(4'b1010, 4'b0110, 1'b1, 1'b0);
        check("d_case3", 32'(D), 32'h03);
        do_op(4'b1111, 4'b1111, 1'b1, 1'b0);
        check("d_case4", 32'(D), 32'h1F);
        idle_check();
        do_op(4'b0000, 4'b1111, 1'b1, 1'b0);
        check("d_wrap", 32'(D), 32'h10);
        idle_check();

        // Start re-pulsed with new operands mid-shift is ignored
        do_op(4'b1100, 4'b0101, 1'b0, 1'b1);
        check("d_poke", 32'(D), 32'h07);
        idle_check();

        // Reset asserted just after the second shift edge aborts the operation
        A     = 4'b0101;
        B     = 4'b0011;
        Bin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_d", 32'(D), 32'd0);
`ifdef SUBTRATOR_OVF_EN
        check("mid_rst_ovf", 32'(ovf), 32'd0);
`endif
        #3;
        rst = 1'b0;
        exp_d = '0;
        for (int i = 0; i < int'(N) + 2; i++) begin
            tick();
            check("no_done_after_rst", 32'(done), 32'd0);
            check("no_busy_after_rst", 32'(busy), 32'd0);
        end

        // Random operations, sometimes chained back-to-back in the DONE cycle
        for (int k = 0; k < 24; k++) begin
            do_op(N'($urandom), N'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 0) begin
                idle_check();
            end
        end
        idle_check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
